// File: rtl/acc_spi_pkg.sv
// Shared definitions for the accelerometer SPI reader.
// Contents:
//   spi_state_t  - transaction FSM states
//   XFER_BITS    - SCLK periods per transaction (8 command + 16 data)
//   CMD_*        - bit positions inside the command byte
//   build_cmd    - assembles the read command byte from a register address
package acc_spi_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        CS_SETUP = 2'd1,
        XFER     = 2'd2,
        CS_HOLD  = 2'd3
    } spi_state_t;

    localparam int XFER_BITS    = 24;
    localparam int CMD_BITS     = 8;
    localparam int CMD_READ_POS = 7;
    localparam int CMD_MB_POS   = 6;
    localparam int CMD_ADDR_MSB = 5;
    localparam int BIT_CNT_W    = 5;

    // Read + multi-byte flags on top, six address bits below.
    function automatic logic [7:0] build_cmd(input logic [CMD_ADDR_MSB:0] addr);
        logic [7:0] cmd;
        cmd                 = '0;
        cmd[CMD_READ_POS]   = 1'b1;
        cmd[CMD_MB_POS]     = 1'b1;
        cmd[CMD_ADDR_MSB:0] = addr;
        return cmd;
    endfunction

endpackage

// File: rtl/spi_sclk_div.sv
// SCLK half-period timer.
// Ports:
//   clk       - system clock
//   reset     - asynchronous active-low reset
//   en        - count while high; held at zero while low
//   half_done - high in the last clk cycle of each CLK_DIV-cycle half period
module spi_sclk_div #(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    output logic half_done
);

    localparam int            CW   = $clog2(CLK_DIV);
    localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

    logic [CW-1:0] cnt;

    assign half_done = en && (cnt == LAST);

    // Clearing while disabled makes the first half after enable exactly CLK_DIV long.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt <= '0;
        end else if (!en || cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/acc_spi_reader.sv
// Periodic SPI mode-3 reader for a 16-bit accelerometer sample.
// Every SAMPLE_PERIOD clocks a tick starts a 24-bit transaction: an 8-bit
// read/multi-byte command for REG_ADDR followed by two data bytes, low byte
// first. The assembled sample is published on acc with a one-cycle acc_valid.
// Ports:
//   clk       - system clock
//   reset     - asynchronous active-low reset
//   spi_sclk  - SPI clock, idle high
//   spi_cs_n  - sensor chip select, active-low
//   spi_mosi  - command data to sensor
//   spi_miso  - data from sensor
//   acc       - latest complete acceleration sample
//   acc_valid - one-cycle pulse when acc updates
//   busy      - high while spi_cs_n is low
module acc_spi_reader
    import acc_spi_pkg::*;
#(
    parameter int         CLK_DIV       = 4,
    parameter int         SAMPLE_PERIOD = 1000,
    parameter logic [7:0] REG_ADDR      = 8'h32
) (
    input  logic        clk,
    input  logic        reset,
    output logic        spi_sclk,
    output logic        spi_cs_n,
    output logic        spi_mosi,
    input  logic        spi_miso,
    output logic [15:0] acc,
    output logic        acc_valid,
    output logic        busy
);

    localparam int                   PW             = (SAMPLE_PERIOD > 1) ? $clog2(SAMPLE_PERIOD) : 1;
    localparam logic [PW-1:0]        PERIOD_LAST    = PW'(SAMPLE_PERIOD - 1);
    localparam logic [7:0]           CMD            = build_cmd(REG_ADDR[CMD_ADDR_MSB:0]);
    localparam logic [BIT_CNT_W-1:0] LAST_BIT       = BIT_CNT_W'(XFER_BITS - 1);
    localparam logic [BIT_CNT_W-1:0] FIRST_DATA_BIT = BIT_CNT_W'(CMD_BITS);

    spi_state_t           state;
    logic [PW-1:0]        period_cnt;
    logic                 tick;
    logic [BIT_CNT_W-1:0] bit_cnt;
    logic                 half_done;
    logic                 load_tx;
    logic                 shift_tx;
    logic                 sample_rx;
    logic [7:0]           tx_sr;
    logic [15:0]          rx_sr;

    spi_sclk_div #(
        .CLK_DIV(CLK_DIV)
    ) u_div (
        .clk      (clk),
        .reset    (reset),
        .en       (state != IDLE),
        .half_done(half_done)
    );

    assign tick = (period_cnt == PERIOD_LAST);

    // Free-running sample period; ticks seen outside IDLE are simply lost.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            period_cnt <= '0;
        end else if (tick) begin
            period_cnt <= '0;
        end else begin
            period_cnt <= period_cnt + 1'b1;
        end
    end

    // spi_sclk low = low half in progress; its end is the rising SCLK edge.
    assign load_tx   = (state == CS_SETUP) && half_done;
    assign sample_rx = (state == XFER) && half_done && !spi_sclk && (bit_cnt >= FIRST_DATA_BIT);
    assign shift_tx  = (state == XFER) && half_done && spi_sclk && (bit_cnt != LAST_BIT);

    // After the command bits the transmit register has shifted to all zeros,
    // which is exactly the MOSI level wanted for the data bytes.
    always_ff @(posedge clk) begin
        if (load_tx) begin
            tx_sr <= {CMD[6:0], 1'b0};
        end else if (shift_tx) begin
            tx_sr <= {tx_sr[6:0], 1'b0};
        end
        if (sample_rx) begin
            rx_sr <= {rx_sr[14:0], spi_miso};
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            spi_cs_n  <= 1'b1;
            spi_sclk  <= 1'b1;
            spi_mosi  <= 1'b0;
            acc       <= '0;
            acc_valid <= 1'b0;
            busy      <= 1'b0;
            bit_cnt   <= '0;
        end else begin
            acc_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (tick) begin
                        state    <= CS_SETUP;
                        spi_cs_n <= 1'b0;
                        busy     <= 1'b1;
                    end
                end
                CS_SETUP: begin
                    if (half_done) begin
                        state    <= XFER;
                        spi_sclk <= 1'b0;
                        spi_mosi <= CMD[7];
                        bit_cnt  <= '0;
                    end
                end
                XFER: begin
                    if (half_done) begin
                        if (!spi_sclk) begin
                            spi_sclk <= 1'b1;
                        end else if (bit_cnt == LAST_BIT) begin
                            state <= CS_HOLD;
                        end else begin
                            spi_sclk <= 1'b0;
                            spi_mosi <= tx_sr[7];
                            bit_cnt  <= bit_cnt + 1'b1;
                        end
                    end
                end
                CS_HOLD: begin
                    if (half_done) begin
                        state     <= IDLE;
                        spi_cs_n  <= 1'b1;
                        busy      <= 1'b0;
                        // First received byte sits in rx_sr[15:8] and is the low byte.
                        acc       <= {rx_sr[7:0], rx_sr[15:8]};
                        acc_valid <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_acc_spi_reader.sv
// Directed bench for acc_spi_reader: instance A (CLK_DIV=2, SAMPLE_PERIOD=200)
// talks to a mode-3 slave model; instance B (SAMPLE_PERIOD=60) shows ticks
// being dropped while a transaction is in flight.
module tb_acc_spi_reader;

    logic        clk = 1'b0;
    logic        reset_n = 1'b1;

    logic        sclk_a, cs_a, mosi_a, valid_a, busy_a;
    logic        miso_a = 1'b0;
    logic [15:0] acc_a;
    logic        sclk_b, cs_b, mosi_b, valid_b, busy_b;
    logic        miso_b = 1'b0;
    logic [15:0] acc_b;

    int pass_cnt = 0;
    int total_cnt = 0;
    int rel = 0;
    int t_last = 0;

    int          cyc = 0;
    int          rise_cnt = 0;
    int          viol = 0;
    int          win_err = 0;
    int          last_rise = 0;
    int          valid_cnt = 0;
    logic [23:0] mosi_cap = '0;
    logic        prev_sclk = 1'b1;
    logic        prev_cs = 1'b1;
    logic        prev_mosi = 1'b0;

    logic [23:0] frame = '0;
    logic [15:0] slave_word = '0;

    always #5 clk = ~clk;

    acc_spi_reader #(.CLK_DIV(2), .SAMPLE_PERIOD(200), .REG_ADDR(8'h32)) dut_a (
        .clk(clk), .reset(reset_n), .spi_sclk(sclk_a), .spi_cs_n(cs_a), .spi_mosi(mosi_a),
        .spi_miso(miso_a), .acc(acc_a), .acc_valid(valid_a), .busy(busy_a)
    );

    acc_spi_reader #(.CLK_DIV(2), .SAMPLE_PERIOD(60), .REG_ADDR(8'h32)) dut_b (
        .clk(clk), .reset(reset_n), .spi_sclk(sclk_b), .spi_cs_n(cs_b), .spi_mosi(mosi_b),
        .spi_miso(miso_b), .acc(acc_b), .acc_valid(valid_b), .busy(busy_b)
    );

    // Slave: loads its frame when CS falls, shifts a bit out on each SCLK fall.
    always @(negedge sclk_a or negedge cs_a) begin
        if (sclk_a === 1'b1) begin
            frame <= {8'h00, slave_word[7:0], slave_word[15:8]};
        end else if (cs_a === 1'b0) begin
            miso_a <= frame[23];
            frame  <= {frame[22:0], 1'b0};
        end
    end

    // Bus monitor on instance A, sampled on clk.
    always @(posedge clk) begin
        cyc       <= cyc + 1;
        prev_sclk <= sclk_a;
        prev_cs   <= cs_a;
        prev_mosi <= mosi_a;
        if (valid_a === 1'b1) valid_cnt <= valid_cnt + 1;
        if (prev_cs === 1'b1 && cs_a === 1'b0) begin
            rise_cnt <= 0;
            mosi_cap <= '0;
        end else if (cs_a === 1'b0 && prev_sclk === 1'b0 && sclk_a === 1'b1) begin
            rise_cnt <= rise_cnt + 1;
            mosi_cap <= {mosi_cap[22:0], mosi_a};
        end
        if (reset_n && cs_a === 1'b0 && prev_sclk === 1'b1 && sclk_a === 1'b1 && mosi_a !== prev_mosi)
            viol <= viol + 1;
        if (reset_n && prev_cs === 1'b0 && cs_a === 1'b1) begin
            last_rise <= rise_cnt;
            if (rise_cnt != 24) win_err <= win_err + 1;
        end
    end

    task automatic wait_pulse(input bit use_b, input int max_cyc, output int t, output bit ok);
        ok = 1'b0;
        t  = 0;
        for (int i = 0; i < max_cyc; i++) begin
            @(negedge clk);
            if ((use_b ? valid_b : valid_a) === 1'b1) begin
                ok = 1'b1;
                t  = cyc;
                break;
            end
        end
    endtask

    task automatic wait_cs_low(input int max_cyc, output int t, output bit ok);
        ok = 1'b0;
        t  = 0;
        for (int i = 0; i < max_cyc; i++) begin
            @(negedge clk);
            if (cs_a === 1'b0) begin
                ok = 1'b1;
                t  = cyc;
                break;
            end
        end
    endtask

    task automatic test_reset();
        #1 reset_n = 1'b0;
        #1;
        total_cnt++; if (cs_a !== 1'b1) $display("FAIL reset_cs_n: got %b want 1", cs_a); else pass_cnt++;
        total_cnt++; if (sclk_a !== 1'b1) $display("FAIL reset_sclk: got %b want 1", sclk_a); else pass_cnt++;
        total_cnt++; if (mosi_a !== 1'b0) $display("FAIL reset_mosi: got %b want 0", mosi_a); else pass_cnt++;
        total_cnt++; if (acc_a !== 16'h0000) $display("FAIL reset_acc: got %h want 0000", acc_a); else pass_cnt++;
        total_cnt++; if (valid_a !== 1'b0) $display("FAIL reset_valid: got %b want 0", valid_a); else pass_cnt++;
        total_cnt++; if (busy_a !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy_a); else pass_cnt++;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        rel = cyc;
    endtask

    task automatic test_basic();
        int  t;
        bit  ok;
        slave_word = 16'h1234;
        wait_cs_low(400, t, ok);
        total_cnt++; if (!ok || t != rel + 200) $display("FAIL basic_cs_time: got %0d want %0d", t - rel, 200); else pass_cnt++;
        total_cnt++; if (busy_a !== 1'b1) $display("FAIL basic_busy_hi: got %b want 1", busy_a); else pass_cnt++;
        wait_pulse(1'b0, 200, t, ok);
        total_cnt++; if (!ok || t != rel + 300) $display("FAIL basic_valid_time: got %0d want %0d", t - rel, 300); else pass_cnt++;
        total_cnt++; if (acc_a !== 16'h1234) $display("FAIL basic_acc: got %h want 1234", acc_a); else pass_cnt++;
        total_cnt++; if (busy_a !== 1'b0) $display("FAIL basic_busy_lo: got %b want 0", busy_a); else pass_cnt++;
        total_cnt++; if (cs_a !== 1'b1) $display("FAIL basic_cs_hi: got %b want 1", cs_a); else pass_cnt++;
        total_cnt++; if (mosi_cap !== 24'hF20000) $display("FAIL basic_mosi: got %h want f20000", mosi_cap); else pass_cnt++;
        t_last = t;
        slave_word = 16'hFFFF;
        @(negedge clk);
        total_cnt++; if (valid_a !== 1'b0) $display("FAIL basic_valid_width: got %b want 0", valid_a); else pass_cnt++;
        repeat (2) @(negedge clk);
        total_cnt++; if (last_rise !== 24) $display("FAIL basic_sclk_edges: got %0d want 24", last_rise); else pass_cnt++;
    endtask

    task automatic test_ones_zeros();
        int  t;
        bit  ok;
        wait_pulse(1'b0, 300, t, ok);
        total_cnt++; if (!ok || t != t_last + 200) $display("FAIL ones_time: got %0d want %0d", t - t_last, 200); else pass_cnt++;
        total_cnt++; if (acc_a !== 16'hFFFF) $display("FAIL ones_acc: got %h want ffff", acc_a); else pass_cnt++;
        t_last = t;
        slave_word = 16'h0000;
        wait_pulse(1'b0, 300, t, ok);
        total_cnt++; if (!ok || t != t_last + 200) $display("FAIL zeros_time: got %0d want %0d", t - t_last, 200); else pass_cnt++;
        total_cnt++; if (acc_a !== 16'h0000) $display("FAIL zeros_acc: got %h want 0000", acc_a); else pass_cnt++;
        t_last = t;
    endtask

    task automatic test_back_to_back();
        logic [15:0] words [3];
        logic [15:0] prev_word;
        int          t;
        int          v0;
        bit          ok;
        words[0] = 16'h0001;
        words[1] = 16'h8000;
        words[2] = 16'h7FFF;
        prev_word = 16'h0000;
        repeat (2) @(negedge clk);
        v0 = valid_cnt;
        for (int i = 0; i < 3; i++) begin
            slave_word = words[i];
            wait_cs_low(300, t, ok);
            repeat (50) @(negedge clk);
            total_cnt++; if (acc_a !== prev_word) $display("FAIL seq%0d_hold: got %h want %h", i, acc_a, prev_word); else pass_cnt++;
            wait_pulse(1'b0, 200, t, ok);
            total_cnt++; if (!ok || t != t_last + 200) $display("FAIL seq%0d_time: got %0d want %0d", i, t - t_last, 200); else pass_cnt++;
            total_cnt++; if (acc_a !== words[i]) $display("FAIL seq%0d_acc: got %h want %h", i, acc_a, words[i]); else pass_cnt++;
            t_last = t;
            prev_word = words[i];
        end
        repeat (2) @(negedge clk);
        total_cnt++; if (valid_cnt - v0 != 3) $display("FAIL seq_pulses: got %0d want 3", valid_cnt - v0); else pass_cnt++;
    endtask

    task automatic test_reset_mid();
        int  t;
        int  vc;
        bit  ok;
        slave_word = 16'h5555;
        wait_cs_low(300, t, ok);
        for (int i = 0; i < 300 && rise_cnt != 15; i++) @(negedge clk);
        reset_n = 1'b0;
        #1;
        total_cnt++; if (cs_a !== 1'b1) $display("FAIL mid_cs_n: got %b want 1", cs_a); else pass_cnt++;
        total_cnt++; if (sclk_a !== 1'b1) $display("FAIL mid_sclk: got %b want 1", sclk_a); else pass_cnt++;
        total_cnt++; if (mosi_a !== 1'b0) $display("FAIL mid_mosi: got %b want 0", mosi_a); else pass_cnt++;
        total_cnt++; if (busy_a !== 1'b0) $display("FAIL mid_busy: got %b want 0", busy_a); else pass_cnt++;
        total_cnt++; if (acc_a !== 16'h0000) $display("FAIL mid_acc: got %h want 0000", acc_a); else pass_cnt++;
        repeat (3) @(negedge clk);
        vc = valid_cnt;
        reset_n = 1'b1;
        rel = cyc;
        slave_word = 16'hA55A;
        wait_cs_low(400, t, ok);
        total_cnt++; if (!ok || t != rel + 200) $display("FAIL mid_restart_time: got %0d want %0d", t - rel, 200); else pass_cnt++;
        total_cnt++; if (valid_cnt != vc) $display("FAIL mid_no_valid: got %0d pulses want 0", valid_cnt - vc); else pass_cnt++;
        total_cnt++; if (acc_a !== 16'h0000) $display("FAIL mid_acc_kept: got %h want 0000", acc_a); else pass_cnt++;
        wait_pulse(1'b0, 200, t, ok);
        total_cnt++; if (!ok || t != rel + 300) $display("FAIL mid_valid_time: got %0d want %0d", t - rel, 300); else pass_cnt++;
        total_cnt++; if (acc_a !== 16'hA55A) $display("FAIL mid_acc_new: got %h want a55a", acc_a); else pass_cnt++;
    endtask

    task automatic test_dropped_ticks();
        int t1, t2, t3;
        bit ok1, ok2, ok3;
        wait_pulse(1'b1, 400, t1, ok1);
        total_cnt++; if (!ok1 || (t1 - rel) % 120 != 40) $display("FAIL drop_phase: got %0d want 40 mod 120", t1 - rel); else pass_cnt++;
        total_cnt++; if (busy_b !== 1'b0 || cs_b !== 1'b1 || sclk_b !== 1'b1 || mosi_b !== 1'b0)
            $display("FAIL drop_idle_bus: got busy=%b cs=%b sclk=%b mosi=%b want 0 1 1 0", busy_b, cs_b, sclk_b, mosi_b);
        else pass_cnt++;
        total_cnt++; if (acc_b !== 16'h0000) $display("FAIL drop_acc: got %h want 0000", acc_b); else pass_cnt++;
        wait_pulse(1'b1, 400, t2, ok2);
        total_cnt++; if (!ok2 || t2 - t1 != 120) $display("FAIL drop_interval1: got %0d want 120", t2 - t1); else pass_cnt++;
        wait_pulse(1'b1, 400, t3, ok3);
        total_cnt++; if (!ok3 || t3 - t2 != 120) $display("FAIL drop_interval2: got %0d want 120", t3 - t2); else pass_cnt++;
    endtask

    task automatic test_protocol();
        repeat (2) @(negedge clk);
        total_cnt++; if (viol != 0) $display("FAIL proto_mosi_stable: got %0d changes want 0", viol); else pass_cnt++;
        total_cnt++; if (win_err != 0) $display("FAIL proto_edge_count: got %0d bad windows want 0", win_err); else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_ones_zeros();
        test_back_to_back();
        test_reset_mid();
        test_dropped_ticks();
        test_protocol();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks done", pass_cnt, total_cnt);
        $fatal(1, "time limit");
    end

endmodule
